// File: rtl/chip8_memory.sv
// CHIP-8 memory responder: 4 KiB byte RAM with the hex font ROM at the bottom,
// a power-on clear of RAM above the font, and a byte-stream program loader.
module chip8_memory #(
  parameter int unsigned MEM_SIZE      = 4096,
  parameter logic [15:0] FONT_END      = 16'h050,
  parameter logic [15:0] PROGRAM_START = 16'h200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_overflow,
  output logic        busy
);

  localparam int unsigned    AW         = $clog2(MEM_SIZE);
  localparam logic [AW-1:0]  FONT_END_A = FONT_END[AW-1:0];
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(MEM_SIZE - 1);
  localparam logic [AW:0]    LOAD_START = {1'b0, PROGRAM_START[AW-1:0]};

  localparam logic [7:0] FONT_ROM [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACK, S_LOAD} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [AW:0]   load_ptr_q, load_ptr_d;   // MSB set means pointer ran past the last byte
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          load_overflow_q, load_overflow_d;

  logic [7:0]    ram [MEM_SIZE];
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;

  logic [AW-1:0] cpu_addr;
  logic          cpu_in_font;
  logic          unused_addr_hi;

  assign cpu_addr       = cpu_address[AW-1:0];
  assign cpu_in_font    = cpu_addr < FONT_END_A;
  assign unused_addr_hi = ^cpu_address[15:AW];

  always_comb begin
    state_d         = state_q;
    clr_ptr_d       = clr_ptr_q;
    load_ptr_d      = load_ptr_q;
    cpu_rdata_d     = cpu_rdata_q;
    load_overflow_d = load_overflow_q;
    ram_we          = 1'b0;
    ram_addr        = clr_ptr_q;
    ram_wdata       = '0;
    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cpu_req) begin
          state_d = S_ACK;
          if (cpu_we) begin
            ram_we    = !cpu_in_font;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
          end else begin
            cpu_rdata_d = cpu_in_font ? FONT_ROM[cpu_addr[6:0]] : ram[cpu_addr];
          end
        end else if (load_valid) begin
          state_d = S_LOAD;
        end
      end
      S_ACK: state_d = S_IDLE;
      S_LOAD: begin
        if (load_valid) begin
          if (load_ptr_q[AW]) begin
            load_overflow_d = 1'b1;
          end else begin
            ram_we     = 1'b1;
            ram_addr   = load_ptr_q[AW-1:0];
            ram_wdata  = load_data;
            load_ptr_d = load_ptr_q + 1'b1;
          end
          if (load_last) begin
            state_d    = S_IDLE;
            load_ptr_d = LOAD_START;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_CLEAR;
      clr_ptr_q       <= FONT_END_A;
      load_ptr_q      <= LOAD_START;
      cpu_rdata_q     <= '0;
      load_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_ptr_q       <= clr_ptr_d;
      load_ptr_q      <= load_ptr_d;
      cpu_rdata_q     <= cpu_rdata_d;
      load_overflow_q <= load_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram[ram_addr] <= ram_wdata;
  end

  assign cpu_ack       = (state_q == S_ACK);
  assign cpu_rdata     = cpu_rdata_q;
  assign load_ready    = (state_q == S_LOAD);
  assign load_overflow = load_overflow_q;
  assign busy          = (state_q == S_CLEAR) || (state_q == S_LOAD);

endmodule

// File: tb/tb_chip8_memory.sv
// Directed-vector bench for chip8_memory: clear, font, aliasing, loader and overflow.
module tb_chip8_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] img_q [$];

  always #5 clk = ~clk;

  chip8_memory #(.MEM_SIZE(4096), .FONT_END(16'h050), .PROGRAM_START(16'h200)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_overflow(load_overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns one cycle after the ack.
  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_address = addr; cpu_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 100);
    rd = cpu_rdata;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    int lat;
    cpu_access(1'b0, addr, 8'h00, rd, lat);
    check(tag, 32'(rd), 32'(exp));
  endtask

  task automatic wr(input string tag, input logic [15:0] addr, input logic [7:0] d);
    logic [7:0] rd;
    int lat;
    cpu_access(1'b1, addr, d, rd, lat);
    check(tag, 32'(lat), 1);
  endtask

  // Streams img_q with no gaps; returns at the negedge after the last byte is taken.
  task automatic run_load(output int ready_cycles);
    int i = 0;
    int cyc = 0;
    logic acc;
    ready_cycles = 0;
    load_valid = 1'b1; load_data = img_q[0]; load_last = (img_q.size() == 1);
    while (i < img_q.size() && cyc < img_q.size() + 50) begin
      acc = load_ready;
      if (acc) ready_cycles++;
      @(negedge clk);
      cyc++;
      if (acc) begin
        i++;
        if (i < img_q.size()) begin
          load_data = img_q[i];
          load_last = (i == img_q.size() - 1);
        end
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    if (i < img_q.size()) check("load_timeout", 32'(i), 32'(img_q.size()));
  endtask

  initial begin
    logic [7:0] rd;
    int lat, rc, bad, n;
    reset = 1'b1; cpu_address = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 1);
    check("rst_ack",   32'(cpu_ack), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_ready", 32'(load_ready), 0);
    check("rst_ovf",   32'(load_overflow), 0);

    // 1: request held through CLEAR
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 16'h0300;
    bad = 0;
    for (int i = 1; i <= 4015; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cpu_ack !== 1'b0 || load_ready !== 1'b0) bad++;
    end
    check("clear_stall", 32'(bad), 0);
    @(negedge clk);
    check("clear_end_busy", 32'(busy), 0);
    check("clear_end_ack",  32'(cpu_ack), 0);
    @(negedge clk);
    check("clear_ack",   32'(cpu_ack), 1);
    check("clear_rdata", 32'(cpu_rdata), 0);
    cpu_req = 1'b0;
    @(negedge clk);

    // 2: font ROM
    cpu_access(1'b0, 16'h0000, 8'h00, rd, lat);
    check("font_000", 32'(rd), 'hF0);
    check("ack_latency", 32'(lat), 1);
    rd_chk("font_04F", 16'h004F, 8'h80);
    rd_chk("font_024", 16'h0024, 8'h10);
    rd_chk("font_037", 16'h0037, 8'hE0);
    rd_chk("ram_050",  16'h0050, 8'h00);

    // 3: aliasing and font write-protect
    wr("wr_1FFF", 16'h1FFF, 8'hAB);
    rd_chk("alias_0FFF", 16'h0FFF, 8'hAB);
    wr("wr_000", 16'h0000, 8'h55);
    rd_chk("font_ro", 16'h0000, 8'hF0);
    wr("wr_050", 16'h0050, 8'h5A);
    rd_chk("rd_050", 16'h0050, 8'h5A);
    check("rdata_hold", 32'(cpu_rdata), 'h5A);

    // 4: loader
    img_q = '{8'h12, 8'h34, 8'h56};
    run_load(rc);
    check("load_ready_cnt", 32'(rc), 3);
    check("load_end_busy",  32'(busy), 0);
    rd_chk("ld_200", 16'h0200, 8'h12);
    rd_chk("ld_201", 16'h0201, 8'h34);
    rd_chk("ld_202", 16'h0202, 8'h56);
    img_q = '{8'hAA};
    run_load(rc);
    rd_chk("ld2_200", 16'h0200, 8'hAA);
    rd_chk("ld2_201", 16'h0201, 8'h34);

    // 5: CPU stalls during LOAD; then CPU wins a simultaneous start
    img_q = '{8'h77, 8'h88, 8'h99};
    fork
      run_load(rc);
      begin
        n = 0;
        while (!load_ready && n < 20) begin @(negedge clk); n++; end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 16'h0202;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 50);
        check("stall_ack_delay", 32'(n), 4);
        check("stall_rdata", 32'(cpu_rdata), 'h99);
        cpu_req = 1'b0;
        @(negedge clk);
      end
    join
    img_q = '{8'h3C};
    fork
      run_load(rc);
      begin
        cpu_access(1'b0, 16'h0200, 8'h00, rd, lat);
        check("prio_latency", 32'(lat), 1);
        check("prio_rdata", 32'(rd), 'h77);
      end
    join
    @(negedge clk);
    rd_chk("prio_after", 16'h0200, 8'h3C);

    // 6: overflow
    check("ovf_pre", 32'(load_overflow), 0);
    img_q = {};
    for (int i = 0; i < 3585; i++) img_q.push_back(8'(i));
    run_load(rc);
    check("ovf_set", 32'(load_overflow), 1);
    check("ovf_busy", 32'(busy), 0);
    rd_chk("ovf_200", 16'h0200, 8'h00);
    rd_chk("ovf_2FF", 16'h02FF, 8'hFF);
    rd_chk("ovf_FFE", 16'h0FFE, 8'hFE);
    rd_chk("ovf_FFF", 16'h0FFF, 8'hFF);
    rd_chk("ovf_000", 16'h0000, 8'hF0);
    img_q = '{8'h01};
    run_load(rc);
    check("ovf_sticky", 32'(load_overflow), 1);
    rd_chk("ovf_reload", 16'h0200, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    check("ovf_rst", 32'(load_overflow), 0);
    check("rst2_busy", 32'(busy), 1);
    check("rst2_rdata", 32'(cpu_rdata), 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
